// File: rtl/reservoir_pkg.sv
// reservoir_pkg: shared constants and types for the 16-neuron spiking
// reservoir (reservoir_crossbar and reservoir_neuron).
//
// Contents:
//   N            number of neurons
//   CONN_OFFSET  recurrent sources of neuron j are (j - offset) mod N
//   THRESH       firing threshold on the saturated membrane sum
//   EXT_WEIGHT   current added by an active external excitation line
//   VW           membrane potential width (unsigned)
//   vmem_t       membrane potential type
//   current_t    synaptic current type (range 0..5)
package reservoir_pkg;

    localparam int N          = 16;
    localparam int NUM_CONN   = 3;
    localparam int CONN_OFFSET [NUM_CONN] = '{1, 2, 4};
    localparam int VW         = 6;
    localparam int THRESH     = 8;
    localparam int EXT_WEIGHT = 2;
    localparam int CUR_W      = 3;

    typedef logic [VW-1:0]    vmem_t;
    typedef logic [CUR_W-1:0] current_t;

endpackage

// File: rtl/reservoir_neuron.sv
// reservoir_neuron: one integrate-and-fire neuron.
//
// Ports:
//   clock    rising-edge clock
//   reset    synchronous, active-high; clears membrane and spike
//   write    integrate enable; when low the membrane holds and spike drops
//   current  synaptic current for this cycle (0..5)
//   fire     combinational: this neuron fires on the coming edge
//   spike    registered one-cycle spike pulse
//   v        registered membrane potential
//
// Optional feature macro: RESERVOIR_LEAK_EN -- on a write cycle with zero
// current the membrane decays by one toward zero.
module reservoir_neuron
    import reservoir_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     write,
    input  current_t current,
    output logic     fire,
    output logic     spike,
    output vmem_t    v
);

    localparam logic [VW:0] VMAX = {1'b0, {VW{1'b1}}};

    vmem_t       v_q, v_d;
    logic        spike_q, spike_d;
    logic [VW:0] sum;
    logic [VW:0] sum_sat;

    always_comb begin
        sum     = {1'b0, v_q} + {{(VW + 1 - CUR_W){1'b0}}, current};
        sum_sat = (sum > VMAX) ? VMAX : sum;
        fire    = write && (sum_sat >= (VW + 1)'(THRESH));

        v_d     = v_q;
        spike_d = 1'b0;
        if (write) begin
            if (fire) begin
                v_d     = '0;
                spike_d = 1'b1;
            end else begin
`ifdef RESERVOIR_LEAK_EN
                // No input this cycle: decay toward rest, never below zero.
                if (current == '0 && v_q != '0) begin
                    v_d = v_q - vmem_t'(1);
                end else begin
                    v_d = sum_sat[VW-1:0];
                end
`else
                v_d = sum_sat[VW-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;
    assign v     = v_q;

endmodule

// File: rtl/reservoir_crossbar.sv
// reservoir_crossbar: 16-neuron spiking reservoir with a fixed recurrent
// crossbar. Neuron j integrates spikes from neurons (j-1), (j-2), (j-4)
// mod 16 plus EXT_WEIGHT when Ein_ext[j % 8] is set.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high
//   Ein_ext       [0:7] external excitation, bit 0 is the MSB
//   spikes_in     [0:15] presynaptic spikes, neuron i = bit i
//   write         integrate enable; when low state holds, outputs pulse low
//   flush_weight  registered pulse: some neuron fired on the last edge
//   spike_record  [0:15] registered spikes, neuron j = bit j
//   E_reg         [0:15] registered per-neuron external excitation
//
// Optional feature macro: RESERVOIR_LEAK_EN (membrane leak, in reservoir_neuron).
module reservoir_crossbar
    import reservoir_pkg::*;
#(
    parameter int Spike_neurons = 15,
    parameter int External_Ein  = 7,
    parameter int E_reg_width   = 15
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [0:External_Ein]  Ein_ext,
    input  logic [0:15]            spikes_in,
    input  logic                   write,
    output logic                   flush_weight,
    output logic [0:Spike_neurons] spike_record,
    output logic [0:E_reg_width]   E_reg
);

    logic [0:N-1]         fire_vec;
    logic [0:E_reg_width] e_reg_q, e_reg_d;
    logic                 flush_q, flush_d;

    for (genvar j = 0; j < N; j++) begin : g_neuron
        localparam int SRC0 = (j + N - CONN_OFFSET[0]) % N;
        localparam int SRC1 = (j + N - CONN_OFFSET[1]) % N;
        localparam int SRC2 = (j + N - CONN_OFFSET[2]) % N;
        localparam int EIDX = j % (External_Ein + 1);

        current_t cur;
        vmem_t    v_mem;

        always_comb begin
            cur = current_t'(spikes_in[SRC0])
                + current_t'(spikes_in[SRC1])
                + current_t'(spikes_in[SRC2])
                + (Ein_ext[EIDX] ? current_t'(EXT_WEIGHT) : current_t'(0));
        end

        reservoir_neuron u_neuron (
            .clock   (clock),
            .reset   (reset),
            .write   (write),
            .current (cur),
            .fire    (fire_vec[j]),
            .spike   (spike_record[j]),
            .v       (v_mem)
        );

        // A neuron resets on reaching threshold, so the stored membrane
        // must always sit below it.
        a_below_thresh : assert property (@(posedge clock) v_mem < vmem_t'(THRESH));

        assign e_reg_d[j] = write ? Ein_ext[EIDX] : e_reg_q[j];
    end

    // fire_vec is already gated by write, so a hold cycle yields no pulse.
    assign flush_d = |fire_vec;

    always_ff @(posedge clock) begin
        if (reset) begin
            e_reg_q <= '0;
            flush_q <= 1'b0;
        end else begin
            e_reg_q <= e_reg_d;
            flush_q <= flush_d;
        end
    end

    assign E_reg        = e_reg_q;
    assign flush_weight = flush_q;

endmodule

// File: tb/tb_reservoir_crossbar.sv
module tb_reservoir_crossbar;

    logic        clock;
    logic        reset;
    logic [0:7]  Ein_ext;
    logic [0:15] spikes_in;
    logic        write;
    logic        flush_weight;
    logic [0:15] spike_record;
    logic [0:15] E_reg;

    int checks = 0;
    int errors = 0;

    reservoir_crossbar dut (
        .clock        (clock),
        .reset        (reset),
        .Ein_ext      (Ein_ext),
        .spikes_in    (spikes_in),
        .write        (write),
        .flush_weight (flush_weight),
        .spike_record (spike_record),
        .E_reg        (E_reg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic rst, input logic w, input logic [7:0] e, input logic [15:0] s);
        reset     = rst;
        write     = w;
        Ein_ext   = e;
        spikes_in = s;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp_sr, input logic [15:0] exp_e);
        check({tag, ".spike_record"}, spike_record, exp_sr);
        check({tag, ".flush_weight"}, {15'd0, flush_weight}, {15'd0, exp_sr != 16'h0000});
        check({tag, ".E_reg"}, E_reg, exp_e);
    endtask

    logic [15:0] mixed_exp [6];
    logic [15:0] leak_exp [4];

    initial begin
        reset = 1'b1; write = 1'b0; Ein_ext = '0; spikes_in = '0;

        // Reset with arbitrary inputs and write asserted.
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        check_out("reset", 16'h0000, 16'h0000);

        // All-ones drive, I = 5: fires every 2nd edge.
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 8'hFF, 16'hFFFF);
            check_out($sformatf("all_ones_e%0d", k), (k % 2 == 0) ? 16'hFFFF : 16'h0000, 16'hFFFF);
        end

        // External only, I = 2: fires on edges 4, 8, 12.
        step(1'b1, 1'b0, 8'h00, 16'h0000);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 8'hFF, 16'h0000);
            check_out($sformatf("ext_only_e%0d", k), (k % 4 == 0) ? 16'hFFFF : 16'h0000, 16'hFFFF);
        end

        // Mixed: neurons 0 and 3 see I = 3 (period 3), all others I >= 4 (period 2).
        mixed_exp[0] = 16'h0000; mixed_exp[1] = 16'h6FFF; mixed_exp[2] = 16'h9000;
        mixed_exp[3] = 16'h6FFF; mixed_exp[4] = 16'h0000; mixed_exp[5] = 16'hFFFF;
        step(1'b1, 1'b0, 8'h00, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 8'hFF, 16'b1011110111110110);
            check_out($sformatf("mixed_e%0d", k + 1), mixed_exp[k], 16'hFFFF);
        end

        // Hold: V = 5 kept across 3 idle edges while inputs change.
        step(1'b1, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b1, 8'hFF, 16'hFFFF);
        check_out("hold_first", 16'h0000, 16'hFFFF);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 8'h00, 16'h5A5A);
            check_out($sformatf("hold_idle%0d", k), 16'h0000, 16'hFFFF);
        end
        step(1'b0, 1'b1, 8'hFF, 16'hFFFF);
        check_out("hold_resume", 16'hFFFF, 16'hFFFF);

        // Reset in the middle of integration clears V.
        step(1'b0, 1'b1, 8'hFF, 16'hFFFF);
        check_out("midrst_pre", 16'h0000, 16'hFFFF);
        step(1'b1, 1'b1, 8'hFF, 16'hFFFF);
        check_out("midrst_rst", 16'h0000, 16'h0000);
        step(1'b0, 1'b1, 8'hFF, 16'hFFFF);
        check_out("midrst_e1", 16'h0000, 16'hFFFF);
        step(1'b0, 1'b1, 8'hFF, 16'hFFFF);
        check_out("midrst_e2", 16'hFFFF, 16'hFFFF);

        // E_reg mapping: E_reg[j] = Ein_ext[j % 8].
        step(1'b1, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b1, 8'hA5, 16'h0000);
        check_out("ereg_a5", 16'h0000, 16'hA5A5);
        step(1'b0, 1'b1, 8'h3C, 16'h0000);
        check_out("ereg_3c", 16'h0000, 16'h3C3C);

        // Idle membrane behaviour: neurons 0 and 8 charged to 2, then 3 zero-input edges.
`ifdef RESERVOIR_LEAK_EN
        leak_exp[0] = 16'h0000; leak_exp[1] = 16'h0000; leak_exp[2] = 16'h0000; leak_exp[3] = 16'h8080;
`else
        leak_exp[0] = 16'h0000; leak_exp[1] = 16'h0000; leak_exp[2] = 16'h8080; leak_exp[3] = 16'h0000;
`endif
        step(1'b1, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b1, 8'h80, 16'h0000);
        check_out("leak_charge", 16'h0000, 16'h8080);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 8'h00, 16'h0000);
            check_out($sformatf("leak_idle%0d", k), 16'h0000, 16'h0000);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'h80, 16'h0000);
            check_out($sformatf("leak_recharge%0d", k + 1), leak_exp[k], 16'h8080);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
